// File: rtl/fcmp_issue.sv
// fcmp_issue: front-end issuer and in-order writeback collector for the
// single-cycle float less-or-equal comparator. Each request (fle/flt/fge/fgt)
// is mapped onto one le compare by operand swap plus result inversion.
// A circular tracking queue holds {tag, inv, filled, flag} per request so
// results are matched in order and handed to writeback under ready/valid.

module fcmp_issue #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             rstn,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,

    output logic             cmp_valid,
    output logic [31:0]      cmp_x1,
    output logic [31:0]      cmp_x2,
    input  logic             cmp_res_valid,
    input  logic [31:0]      cmp_res,

    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             wb_flag,

    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] FP_ONE = 32'h3f80_0000;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             inv;
        logic             filled;
        logic             flag;
    } entry_t;

    entry_t           ent_q [DEPTH];
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] head_ptr;
    logic [CNT_W-1:0] count;     // allocated entries, filled or not
    logic [CNT_W-1:0] pend_cnt;  // allocated entries still awaiting a result
    logic             err_q;

    logic             op_swap;
    logic             op_inv;
    logic             issue;
    logic             fill;
    logic             pop;
    logic             spurious;
    entry_t           new_ent;
    entry_t           head_ent;

    // Op decode: flt/fge swap operands, flt/fgt invert the le result.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        op_swap = 1'b0;
        op_inv  = 1'b0;
        case (in_op)
            2'b00:   begin op_swap = 1'b0; op_inv = 1'b0; end  // fle
            2'b01:   begin op_swap = 1'b1; op_inv = 1'b1; end  // flt = !(b <= a)
            2'b10:   begin op_swap = 1'b1; op_inv = 1'b0; end  // fge = (b <= a)
            default: begin op_swap = 1'b0; op_inv = 1'b1; end  // fgt = !(a <= b)
        endcase
    end

    // Credit is taken from the registered occupancy only, so wb_ready never
    // reaches in_ready combinationally; the comparator always has a slot.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign issue     = in_valid && in_ready;
    assign cmp_valid = issue;
    assign cmp_x1    = op_swap ? in_b : in_a;
    assign cmp_x2    = op_swap ? in_a : in_b;

    // A result with nothing outstanding is a protocol error and is dropped.
    assign fill     = cmp_res_valid && (pend_cnt != '0);
    assign spurious = cmp_res_valid && (pend_cnt == '0);

    assign head_ent = ent_q[head_ptr];
    assign wb_valid = head_ent.filled;
    assign wb_tag   = head_ent.tag;
    assign wb_flag  = head_ent.flag;
    assign wb_data  = head_ent.flag ? FP_ONE : 32'h0;
    assign pop      = wb_valid && wb_ready;
    assign err      = err_q;

    assign new_ent = '{tag: in_tag, inv: op_inv, filled: 1'b0, flag: 1'b0};

    // Tracking queue: allocate on issue, fill in order, clear on pop.
    // Issue, fill and pop never target the same entry in one cycle: issue
    // needs a free slot, fill an unfilled one, pop a filled one.
    // NOTE: the entry array is reset as well as the pointers; it is tiny and
    // this keeps wb_tag/wb_flag/wb_data at 0 out of reset instead of X.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // read in this block sees the pre-edge value.
            if (issue) begin
                ent_q[alloc_ptr] <= new_ent;
                alloc_ptr        <= alloc_ptr + PTR_W'(1);
            end
            if (fill) begin
                ent_q[fill_ptr].filled <= 1'b1;
                ent_q[fill_ptr].flag   <= (cmp_res != 32'h0) ^ ent_q[fill_ptr].inv;
                fill_ptr               <= fill_ptr + PTR_W'(1);
            end
            if (pop) begin
                ent_q[head_ptr] <= '0;
                head_ptr        <= head_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy and outstanding-result counters.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            count    <= '0;
            pend_cnt <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case ({issue, fill})
                2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (spurious) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fcmp_issue.sv
// tb_fcmp_issue: directed bench for fcmp_issue with a behavioural
// single-cycle le comparator attached to the cmp_* side.

module tb_fcmp_issue;

    localparam int TAG_W = 5;
    localparam int DEPTH = 4;
    localparam logic [31:0] F_ONE  = 32'h3f80_0000;  //  1.0
    localparam logic [31:0] F_TWO  = 32'h4000_0000;  //  2.0
    localparam logic [31:0] F_MTWO = 32'hc000_0000;  // -2.0

    logic             sys_clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             cmp_valid;
    logic [31:0]      cmp_x1;
    logic [31:0]      cmp_x2;
    logic             cmp_res_valid;
    logic [31:0]      cmp_res;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_flag;
    logic             err;

    int checks   = 0;
    int failures = 0;

    fcmp_issue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .cmp_valid     (cmp_valid),
        .cmp_x1        (cmp_x1),
        .cmp_x2        (cmp_x2),
        .cmp_res_valid (cmp_res_valid),
        .cmp_res       (cmp_res),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_tag        (wb_tag),
        .wb_data       (wb_data),
        .wb_flag       (wb_flag),
        .err           (err)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference IEEE-754 single x1 <= x2 (NaN compares false, +0 == -0).
    function automatic logic ref_le(input logic [31:0] x1, input logic [31:0] x2);
        logic nan1, nan2;
        nan1 = (x1[30:23] == 8'hff) && (x1[22:0] != 0);
        nan2 = (x2[30:23] == 8'hff) && (x2[22:0] != 0);
        if (nan1 || nan2)                          return 1'b0;
        if (x1[30:0] == 0 && x2[30:0] == 0)        return 1'b1;
        if (x1[31] != x2[31])                      return x1[31];
        if (!x1[31])                               return x1[30:0] <= x2[30:0];
        return x1[30:0] >= x2[30:0];
    endfunction

    // One-cycle comparator model, reset together with the issuer.
    logic        cmp_v_q;
    logic [31:0] cmp_y_q;
    logic        spur;
    always @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cmp_v_q <= 1'b0;
            cmp_y_q <= 32'h0;
        end else begin
            cmp_v_q <= cmp_valid;
            cmp_y_q <= ref_le(cmp_x1, cmp_x2) ? F_ONE : 32'h0;
        end
    end
    assign cmp_res_valid = cmp_v_q | spur;
    assign cmp_res       = cmp_y_q;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance one cycle; all driving and sampling happens at the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Single request with wb_ready=1: check the mapped operands, the T+2
    // writeback and the pop. Called at a falling edge with an empty queue.
    task automatic do_one(input string nm, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag,
                          input logic [31:0] ex1, input logic [31:0] ex2,
                          input logic exp_flag);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        #1;
        check({nm, ".cmp_valid"}, 32'(cmp_valid), 32'd1);
        check({nm, ".cmp_x1"}, cmp_x1, ex1);
        check({nm, ".cmp_x2"}, cmp_x2, ex2);
        tick();
        in_valid = 1'b0;
        #1;
        check({nm, ".wb_valid_t1"}, 32'(wb_valid), 32'd0);
        tick();
        check({nm, ".wb_valid_t2"}, 32'(wb_valid), 32'd1);
        check({nm, ".wb_tag"}, 32'(wb_tag), 32'(tag));
        check({nm, ".wb_flag"}, 32'(wb_flag), 32'(exp_flag));
        check({nm, ".wb_data"}, wb_data, exp_flag ? F_ONE : 32'h0);
        tick();
        check({nm, ".popped"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        logic [TAG_W-1:0] tagq [$];
        logic             flagq [$];
        int issued, popped, mcount;

        rstn = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = 32'h0; in_b = 32'h0;
        in_tag = '0; wb_ready = 1'b1; spur = 1'b0;

        // Reset values, during and after reset.
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.wb_valid", 32'(wb_valid), 32'd0);
        check("rst.cmp_valid", 32'(cmp_valid), 32'd0);
        check("rst.wb_tag", 32'(wb_tag), 32'd0);
        check("rst.wb_flag", 32'(wb_flag), 32'd0);
        check("rst.wb_data", wb_data, 32'h0);
        check("rst.err", 32'(err), 32'd0);
        repeat (2) @(negedge sys_clk);
        rstn = 1'b1;
        tick();
        check("post_rst.in_ready", 32'(in_ready), 32'd1);
        check("post_rst.wb_valid", 32'(wb_valid), 32'd0);

        // Single-op mapping and inversion.
        do_one("fle_1_2",  2'b00, F_ONE,  F_TWO, 5'd3, F_ONE, F_TWO,  1'b1);
        do_one("flt_2_2",  2'b01, F_TWO,  F_TWO, 5'd7, F_TWO, F_TWO,  1'b0);
        do_one("fgt_m2_1", 2'b11, F_MTWO, F_ONE, 5'd8, F_MTWO, F_ONE, 1'b0);
        do_one("fge_m2_1", 2'b10, F_MTWO, F_ONE, 5'd9, F_ONE, F_MTWO, 1'b0);
        do_one("fge_2_1",  2'b10, F_TWO,  F_ONE, 5'd10, F_ONE, F_TWO, 1'b1);
        do_one("fgt_2_1",  2'b11, F_TWO,  F_ONE, 5'd11, F_TWO, F_ONE, 1'b1);

        // Fill with writeback stalled, hold a fifth request, then drain.
        wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_op = 2'b00; in_a = F_ONE; in_b = F_TWO; in_tag = TAG_W'(i);
            #1;
            check("full.in_ready_before", 32'(in_ready), 32'd1);
            tick();
        end
        in_tag = 5'd5;
        #1;
        check("full.in_ready_low", 32'(in_ready), 32'd0);
        check("full.no_issue", 32'(cmp_valid), 32'd0);
        tick();
        tick();
        check("full.held_in_ready", 32'(in_ready), 32'd0);
        check("full.head_valid", 32'(wb_valid), 32'd1);
        check("full.head_tag1", 32'(wb_tag), 32'd1);
        wb_ready = 1'b1;
        #1;
        check("full.no_comb_ready", 32'(in_ready), 32'd0);
        tick();
        check("full.ready_back", 32'(in_ready), 32'd1);
        check("full.held_issues", 32'(cmp_valid), 32'd1);
        check("full.head_tag2", 32'(wb_tag), 32'd2);
        tick();
        in_valid = 1'b0;
        #1;
        check("full.head_tag3", 32'(wb_tag), 32'd3);
        tick();
        check("full.head_tag4", 32'(wb_tag), 32'd4);
        tick();
        check("full.tag5_valid", 32'(wb_valid), 32'd1);
        check("full.head_tag5", 32'(wb_tag), 32'd5);
        tick();
        check("full.drained", 32'(wb_valid), 32'd0);

        // Full queue, alternating issue and pop, 20 requests across wrap.
        issued = 0; popped = 0; mcount = 0;
        for (int cyc = 0; cyc < 200 && popped < 20; cyc++) begin
            if (issued < 20 && (cyc < 4 || cyc % 2 == 1)) begin
                in_valid = 1'b1; in_op = 2'(issued % 4);
                in_a = F_ONE; in_b = F_TWO; in_tag = TAG_W'(issued + 10);
            end else begin
                in_valid = 1'b0;
            end
            wb_ready = (cyc >= 4) && (cyc % 2 == 0 || issued >= 20);
            #1;
            check("alt.in_ready", 32'(in_ready), 32'(mcount < DEPTH));
            if (wb_valid && wb_ready) begin
                if (tagq.size() == 0) begin
                    check("alt.unexpected_pop", 32'd1, 32'd0);
                end else begin
                    check("alt.wb_tag", 32'(wb_tag), 32'(tagq[0]));
                    check("alt.wb_flag", 32'(wb_flag), 32'(flagq[0]));
                    void'(tagq.pop_front());
                    void'(flagq.pop_front());
                end
                mcount--; popped++;
            end
            if (in_valid && in_ready) begin
                tagq.push_back(in_tag);
                flagq.push_back(in_op < 2'd2);  // 1.0 vs 2.0: le/lt true, ge/gt false
                mcount++; issued++;
            end
            tick();
        end
        in_valid = 1'b0; wb_ready = 1'b1;
        check("alt.popped_all", 32'(popped), 32'd20);
        check("alt.queue_empty", 32'(wb_valid), 32'd0);

        // Spurious comparator result with an empty queue.
        spur = 1'b1;
        #1;
        check("spur.err_not_yet", 32'(err), 32'd0);
        tick();
        spur = 1'b0;
        #1;
        check("spur.err_set", 32'(err), 32'd1);
        check("spur.wb_valid", 32'(wb_valid), 32'd0);
        check("spur.in_ready", 32'(in_ready), 32'd1);
        tick();
        check("spur.err_held", 32'(err), 32'd1);
        do_one("spur_after", 2'b01, F_ONE, F_TWO, 5'd21, F_TWO, F_ONE, 1'b1);
        check("spur.err_still", 32'(err), 32'd1);

        // Asynchronous reset with three entries outstanding.
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = 2'b00; in_a = F_ONE; in_b = F_TWO; in_tag = TAG_W'(12 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("arst.pre_valid", 32'(wb_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst.wb_valid", 32'(wb_valid), 32'd0);
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.err", 32'(err), 32'd0);
        check("arst.wb_tag", 32'(wb_tag), 32'd0);
        @(negedge sys_clk);
        rstn = 1'b1;
        wb_ready = 1'b1;
        do_one("arst_after", 2'b00, F_ONE, F_TWO, 5'd17, F_ONE, F_TWO, 1'b1);
        check("arst.err_after", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
